// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
// Owner indices are the bit positions used in the one-hot grant vector.
package wshb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GNT0     = 2'd1,
      GNT1     = 2'd2,
      HANDOVER = 2'd3
   } arb_state_t;

   localparam logic OWNER_M0 = 1'b0;
   localparam logic OWNER_M1 = 1'b1;

   // One-hot grant vector that goes with a given FSM state.
   function automatic logic [1:0] gnt_of(input arb_state_t s);
      logic [1:0] g;
      g = 2'b00;
      if (s == GNT0) g = 2'b01;
      if (s == GNT1) g = 2'b10;
      return g;
   endfunction

   function automatic arb_state_t gnt_state(input logic owner);
      return (owner == OWNER_M1) ? GNT1 : GNT0;
   endfunction

endpackage

// File: rtl/wshb_arb_pick.sv
// Round-robin next-owner selection for two requesters.
// On a tie the master that did not own the bus last wins.
module wshb_arb_pick
   import wshb_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic owner_o,
   output logic valid_o
);

   always_comb begin
      valid_o = req0_i | req1_i;
      if (req0_i && req1_i)
         owner_o = ~last_i;
      else if (req1_i)
         owner_o = OWNER_M1;
      else
         owner_o = OWNER_M0;
   end

endmodule

// File: rtl/wshb_arbiter2.sv
// Two-master -> one-slave Wishbone arbiter with round-robin grant and a per-grant ack quota.
// Slave-side muxing is combinational from the registered owner state; cti/bte are not routed.
module wshb_arbiter2
   import wshb_arb_pkg::*;
#(
   parameter int ADR_W     = 32,
   parameter int DAT_W     = 32,
   parameter int MAX_BURST = 64,
   localparam int SEL_W    = DAT_W / 8
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             m0_cyc,
   input  logic             m0_stb,
   input  logic             m0_we,
   input  logic [ADR_W-1:0] m0_adr,
   input  logic [SEL_W-1:0] m0_sel,
   input  logic [DAT_W-1:0] m0_dat_ms,
   output logic             m0_ack,

   input  logic             m1_cyc,
   input  logic             m1_stb,
   input  logic             m1_we,
   input  logic [ADR_W-1:0] m1_adr,
   input  logic [SEL_W-1:0] m1_sel,
   input  logic [DAT_W-1:0] m1_dat_ms,
   output logic             m1_ack,

   output logic [DAT_W-1:0] m_dat_sm,

   output logic             s_cyc,
   output logic             s_stb,
   output logic             s_we,
   output logic [ADR_W-1:0] s_adr,
   output logic [SEL_W-1:0] s_sel,
   output logic [DAT_W-1:0] s_dat_ms,
   input  logic             s_ack,
   input  logic [DAT_W-1:0] s_dat_sm,

   output logic [1:0]       gnt
);

   localparam bit QUOTA_ON = (MAX_BURST != 0);
   localparam int CNT_W    = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
   // With no quota the counter is unused; saturate at 1 just to keep it well defined.
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'((MAX_BURST == 0) ? 1 : MAX_BURST);

   arb_state_t       state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
   logic [1:0]       gnt_q;

   logic             req0, req1;
   logic             pick_owner, pick_valid;

   logic             own_cyc;
   logic             own_idx;
   logic             other_req;
   logic             ack_fwd;
   logic [CNT_W-1:0] cnt_inc;

   assign req0 = m0_cyc & m0_stb;
   assign req1 = m1_cyc & m1_stb;

   wshb_arb_pick u_pick (
      .req0_i  (req0),
      .req1_i  (req1),
      .last_i  (last_q),
      .owner_o (pick_owner),
      .valid_o (pick_valid)
   );

   // Slave-side mux and ack return, driven purely by the current owner state so that
   // an asynchronous reset forces every handshake output low without waiting for a clock.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      s_we     = 1'b0;
      s_adr    = '0;
      s_sel    = '0;
      s_dat_ms = '0;
      m0_ack   = 1'b0;
      m1_ack   = 1'b0;
      m_dat_sm = s_dat_sm;

      unique case (state_q)
         GNT0: begin
            s_cyc    = m0_cyc;
            s_stb    = m0_stb;
            s_we     = m0_we;
            s_adr    = m0_adr;
            s_sel    = m0_sel;
            s_dat_ms = m0_dat_ms;
            m0_ack   = s_ack & m0_stb;
         end
         GNT1: begin
            s_cyc    = m1_cyc;
            s_stb    = m1_stb;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_sel    = m1_sel;
            s_dat_ms = m1_dat_ms;
            m1_ack   = s_ack & m1_stb;
         end
         default: ;
      endcase
   end

   // Owner-relative view of the bus, so the GNT0/GNT1 exit logic is written once.
   always_comb begin
      own_idx   = OWNER_M0;
      own_cyc   = 1'b0;
      other_req = 1'b0;
      ack_fwd   = 1'b0;
      if (state_q == GNT0) begin
         own_idx   = OWNER_M0;
         own_cyc   = m0_cyc;
         other_req = req1;
         ack_fwd   = m0_ack;
      end else if (state_q == GNT1) begin
         own_idx   = OWNER_M1;
         own_cyc   = m1_cyc;
         other_req = req0;
         ack_fwd   = m1_ack;
      end
      cnt_inc = (ack_fwd && (ack_cnt_q != CNT_SAT)) ? ack_cnt_q + CNT_W'(1) : ack_cnt_q;
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      ack_cnt_d = ack_cnt_q;

      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d   = gnt_state(pick_owner);
               ack_cnt_d = '0;
            end
         end

         GNT0, GNT1: begin
            ack_cnt_d = cnt_inc;
            if (!own_cyc) begin
               state_d = IDLE;
               last_d  = own_idx;
            end else if (QUOTA_ON && (cnt_inc == CNT_SAT) && other_req) begin
               // Quota used up and the other side is waiting: the ack that got us here
               // is still forwarded, the bus is released on the next edge.
               state_d = HANDOVER;
               last_d  = own_idx;
            end
         end

         HANDOVER: begin
            ack_cnt_d = '0;
            if ((last_q == OWNER_M1) ? req0 : req1)
               state_d = gnt_state(~last_q);
            else
               state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= OWNER_M1;
         ack_cnt_q <= '0;
         gnt_q     <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q   <= state_d;
         last_q    <= last_d;
         ack_cnt_q <= ack_cnt_d;
         gnt_q     <= gnt_of(state_d);
      end
   end

   assign gnt = gnt_q;

endmodule
